// File: rtl/dmem_pkg.sv
// Shared constants and arbiter state encoding for the two-port data-memory arbiter.
package dmem_pkg;

  localparam int DMEM_DATA_W   = 16;
  localparam int DMEM_ADDR_W   = 16;
  localparam int DMEM_DEPTH    = 128;
  localparam int DMEM_MAX_LOCK = 4;

  // Ownership of the previous cycle's grant
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a bounded lock that lets the owner keep the grant.
module rr_arb2
  import dmem_pkg::*;
#(
  parameter int MAX_LOCK = DMEM_MAX_LOCK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam int CW = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);

  arb_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lock_q, lock_nxt;
  logic          prio, prio_nxt;   // port holding round-robin priority
  logic          relock;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      lock_q <= 1'b0;
      prio   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      lock_q <= lock_nxt;
      prio   <= prio_nxt;
    end
  end

  always_comb begin
    gnt       = 2'b00;
    relock    = 1'b0;
    state_nxt = IDLE;
    lock_nxt  = 1'b0;
    prio_nxt  = prio;
    if (state == OWN0 && lock_q && req[0] && cnt < CW'(MAX_LOCK)) begin
      gnt    = 2'b01;
      relock = 1'b1;
    end else if (state == OWN1 && lock_q && req[1] && cnt < CW'(MAX_LOCK)) begin
      gnt    = 2'b10;
      relock = 1'b1;
    end else if (req == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
    // Reset must not let a write reach memory
    if (!rst_n) begin
      gnt    = 2'b00;
      relock = 1'b0;
    end
    if (gnt[0]) begin
      state_nxt = OWN0;
      lock_nxt  = lock[0];
      prio_nxt  = 1'b1;
    end else if (gnt[1]) begin
      state_nxt = OWN1;
      lock_nxt  = lock[1];
      prio_nxt  = 1'b0;
    end
    cnt_nxt = relock ? cnt + CW'(1) : '0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core (port 0) and DMA/debug (port 1).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int MAX_LOCK = DMEM_MAX_LOCK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [1:0]             req, we, lock, gnt, oor, rvalid, err;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata, rdata;
  logic                   sel, any_gnt, g_oor, g_we;

  assign req   = {p1_req, p0_req};
  assign we    = {p1_we, p0_we};
  assign lock  = {p1_lock, p0_lock};
  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};

  rr_arb2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .lock  (lock),
    .gnt   (gnt)
  );

  assign sel     = gnt[1];
  assign any_gnt = |gnt;
  assign g_oor   = oor[sel];
  assign g_we    = we[sel];

  assign mem_address    = any_gnt ? addr[sel]  : '0;
  assign mem_write_data = any_gnt ? wdata[sel] : '0;
  // Out-of-range accesses are granted but never strobe the memory
  assign mem_read  = any_gnt & ~g_oor & ~g_we;
  assign mem_write = any_gnt & ~g_oor &  g_we;

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign oor[p] = {1'b0, addr[p]} >= DEPTH_A;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rvalid[p] <= 1'b0;
        err[p]    <= 1'b0;
        rdata[p]  <= '0;
      end else begin
        rvalid[p] <= gnt[p] & (oor[p] | ~we[p]);
        err[p]    <= gnt[p] & oor[p];
        if (gnt[p] && oor[p])
          rdata[p] <= '0;
        else if (gnt[p] && !we[p])
          rdata[p] <= mem_read_data;
      end
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_err    = err[0];
  assign p1_err    = err[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  logic [15:0] mem [0:127];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[6:0]];
  always @(posedge clk) if (mem_write) mem[mem_address[6:0]] <= mem_write_data;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    tick();
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    idle();
    rst_n = 0;
    // reset: a pending write must not be granted
    p0_req = 1; p0_we = 1; p0_addr = 16'd9; p0_wdata = 16'hDEAD;
    #1;
    chk("rst_gnt0", p0_gnt, 0);
    chk("rst_memwr", mem_write, 0);
    tick();
    chk("rst_rvalid0", p0_rvalid, 0);
    chk("rst_err0", p0_err, 0);
    chk("rst_rdata0", p0_rdata, 0);
    chk("rst_mem9", mem[9], 0);
    idle();
    rst_n = 1;
    tick();

    // single-port write then read-back
    p0_req = 1; p0_we = 1; p0_addr = 16'd5; p0_wdata = 16'h00AA;
    #1;
    chk("wr_gnt0", p0_gnt, 1);
    chk("wr_memwr", mem_write, 1);
    chk("wr_addr", mem_address, 5);
    tick();
    chk("wr_rvalid0", p0_rvalid, 0);
    p0_we = 0;
    #1;
    chk("rd_gnt0", p0_gnt, 1);
    chk("rd_memrd", mem_read, 1);
    tick();
    idle();
    chk("rd_rvalid0", p0_rvalid, 1);
    chk("rd_rdata0", p0_rdata, 16'h00AA);
    tick();
    chk("rd_rvalid_pulse", p0_rvalid, 0);
    chk("rd_rdata_hold", p0_rdata, 16'h00AA);

    // round-robin without lock
    do_reset();
    p0_req = 1; p1_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_gnt0_%0d", i), p0_gnt, (i % 2 == 0));
      chk($sformatf("rr_gnt1_%0d", i), p1_gnt, (i % 2 == 1));
      tick();
    end

    // port 1 lock: p0, then p1 once + 4 locked re-grants, then p0
    do_reset();
    p0_req = 1; p1_req = 1; p1_lock = 1;
    begin
      logic [6:0] exp_p1;
      exp_p1 = 7'b0111110;  // bit i = expected p1_gnt in cycle i
      for (int i = 0; i < 7; i++) begin
        #1;
        chk($sformatf("lk_gnt1_%0d", i), p1_gnt, exp_p1[i]);
        chk($sformatf("lk_gnt0_%0d", i), p0_gnt, !exp_p1[i]);
        tick();
      end
    end

    // out-of-range accesses
    do_reset();
    p0_req = 1; p0_we = 0; p0_addr = 16'd5;
    tick();
    chk("oor_pre_rdata", p0_rdata, 16'h00AA);
    p0_we = 1; p0_addr = 16'd200; p0_wdata = 16'hBEEF;
    #1;
    chk("oor_wr_gnt0", p0_gnt, 1);
    chk("oor_wr_memwr", mem_write, 0);
    chk("oor_wr_memrd", mem_read, 0);
    tick();
    chk("oor_wr_err", p0_err, 1);
    chk("oor_wr_rvalid", p0_rvalid, 1);
    p0_we = 0;
    #1;
    chk("oor_rd_memrd", mem_read, 0);
    tick();
    idle();
    chk("oor_rd_err", p0_err, 1);
    chk("oor_rd_rdata", p0_rdata, 0);
    tick();
    chk("oor_err_pulse", p0_err, 0);

    // simultaneous p0 write and p1 read of the same address
    do_reset();
    p0_req = 1; p0_we = 1; p0_addr = 16'd3; p0_wdata = 16'h1234;
    p1_req = 1; p1_we = 0; p1_addr = 16'd3;
    #1;
    chk("col_gnt0", p0_gnt, 1);
    chk("col_gnt1", p1_gnt, 0);
    tick();
    p0_req = 0;
    #1;
    chk("col_gnt1_next", p1_gnt, 1);
    chk("col_memrd", mem_read, 1);
    tick();
    idle();
    chk("col_rvalid1", p1_rvalid, 1);
    chk("col_rdata1", p1_rdata, 16'h1234);

    // reset in the middle of a port-1 lock
    do_reset();
    p0_req = 1; p0_we = 1; p0_addr = 16'd7; p0_wdata = 16'h5555;
    p1_req = 1; p1_we = 0; p1_addr = 16'd3; p1_lock = 1;
    tick();  // p0 granted (writes mem[7])
    tick();  // p1 granted, lock taken
    #1;
    chk("mid_lock_gnt1", p1_gnt, 1);
    rst_n = 0;
    p0_wdata = 16'h6666;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("mid_rst_gnt0_%0d", i), p0_gnt, 0);
      chk($sformatf("mid_rst_gnt1_%0d", i), p1_gnt, 0);
      chk($sformatf("mid_rst_memwr_%0d", i), mem_write, 0);
      tick();
    end
    chk("mid_rst_mem7", mem[7], 16'h5555);
    rst_n = 1;
    #1;
    chk("post_rst_rvalid1", p1_rvalid, 0);
    chk("post_rst_err0", p0_err, 0);
    chk("post_rst_gnt0", p0_gnt, 1);
    chk("post_rst_gnt1", p1_gnt, 0);
    tick();
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: data width of both ports and of the memory.
REQ-002 Parameter ADDR_W, default 16: address width of both ports and of the memory.
REQ-003 Parameter DEPTH, default 128: number of valid memory words.
REQ-004 Parameter MAX_LOCK, default 4: maximum consecutive grants one port may hold via lock.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 Ports p0_req / p1_req, input, 1 each: request for port 0 (core) and port 1 (DMA/debug).
REQ-008 Ports p0_we / p1_we, input, 1 each: 1 = write, 0 = read.
REQ-009 Ports p0_lock / p1_lock, input, 1 each: request to retain the grant next cycle.
REQ-010 Ports p0_addr / p1_addr, input, ADDR_W each: word address.
REQ-011 Ports p0_wdata / p1_wdata, input, DATA_W each: write data.
REQ-012 Ports p0_gnt / p1_gnt, output, 1 each: access accepted this cycle (combinational).
REQ-013 Ports p0_rvalid / p1_rvalid, output, 1 each: rdata valid (registered pulse).
REQ-014 Ports p0_rdata / p1_rdata, output, DATA_W each: read data (registered, held).
REQ-015 Ports p0_err / p1_err, output, 1 each: out-of-range access pulse (registered).
REQ-016 Port mem_address, output, ADDR_W: address to memory.
REQ-017 Port mem_write_data, output, DATA_W: write data to memory.
REQ-018 Ports mem_read / mem_write, output, 1 each: memory strobes.
REQ-019 Port mem_read_data, input, DATA_W: combinational read data from memory.

Function
REQ-020 At most one of p0_gnt/p1_gnt SHALL be 1 in any cycle; a grant SHALL only be given to a requesting port.
REQ-021 FSM states: IDLE (no grant last cycle), OWN0 (port 0 granted last cycle), OWN1 (port 1 granted last cycle); next state = port granted this cycle, or IDLE if none.
REQ-022 Round-robin: with both requesting and no active lock, the port not granted most recently SHALL win; from IDLE with no history, port 0 wins.
REQ-023 Lock: in OWNx with px_lock=1 and px_req=1 in the previous grant cycle, and lock count < MAX_LOCK, port x SHALL be granted again regardless of the other port.
REQ-024 The lock counter SHALL increment on each locked re-grant, clear on any ownership change or IDLE, and on reaching MAX_LOCK the other requesting port SHALL win next.
REQ-025 Grant cycle: mem_address/mem_write_data SHALL be driven from the granted port; mem_write = we, mem_read = ~we; with no grant, mem_read = mem_write = 0 and mem_address = 0.
REQ-026 Read: at the grant clock edge, mem_read_data SHALL be captured into px_rdata and px_rvalid = 1 for exactly the next cycle (latency 1); px_rdata holds until the next read by that port.
REQ-027 Out-of-range (addr >= DEPTH): grant still given, mem_read and mem_write SHALL be 0, px_err = 1 next cycle, px_rvalid = 1 with px_rdata = 0.
REQ-028 Requester rule: px_req, px_we, px_addr and px_wdata SHALL be held stable until px_gnt; a request dropped before grant is discarded silently.
REQ-029 Back-to-back grants to the same port SHALL be allowed every cycle; throughput is one access per cycle.

Reset
REQ-030 With rst_n=0 at a rising edge: state = IDLE, lock count = 0, round-robin pointer = port 0, all rvalid/err = 0, all rdata = 0.
REQ-031 While rst_n=0, p0_gnt, p1_gnt, mem_read and mem_write SHALL be 0, so no memory write occurs during reset.
REQ-032 Reset during a locked sequence SHALL abandon the lock; the first post-reset grant follows REQ-022.

Structure
REQ-033 Shared package dmem_pkg SHALL hold the FSM state encoding and the default DATA_W, ADDR_W, DEPTH and MAX_LOCK constants.
REQ-034 One sub-module, rr_arb2 (two-way round-robin grant with lock override), SHALL be used; the datapath mux and read capture stay in dmem_arbiter.

Verification
REQ-035 Only p0 writes 0x00AA to addr 5, then reads addr 5: p0_gnt=1 both cycles; p0_rvalid=1 one cycle later; p0_rdata=0x00AA.
REQ-036 Both ports request continuously, no lock: grants alternate p0,p1,p0,p1 starting with p0 after reset.
REQ-037 p1 locks with both requesting, MAX_LOCK=4: p1 granted 5 consecutive cycles (1 plus 4 locked re-grants), then p0 granted.
REQ-038 p0 writes to addr 200 (DEPTH=128): mem_write=0; p0_err=1 next cycle; a later read of addr 200 gives p0_rdata=0.
REQ-039 Same-cycle p0 write 0x1234 to addr 3 and p1 read of addr 3 from IDLE: p0 wins; p1 granted next cycle and reads 0x1234.
REQ-040 rst_n asserted mid-lock with p0_req held: all gnt=0 and mem_write=0 during reset; after release, rvalid=err=0 and p0 granted first.
